// File: rtl/dac_serial_pkg.sv
//==============================================================================
// dac_serial_pkg: shared frame layout, FSM encoding and PD-mode codes for the DAC link. Rev 1.0
//==============================================================================
`default_nettype none

package dac_serial_pkg;

  localparam int FRAME_BITS_DEF = 16;
  localparam int PD_MSB         = 13;
  localparam int PD_LSB         = 12;
  localparam int DATA_MSB       = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/dac_rx_sync_edge.sv
//==============================================================================
// dac_rx_sync_edge: multi-flop synchroniser with one edge-detect flop (rise/fall pulses). Rev 1.0
//==============================================================================
`default_nettype none

module dac_rx_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = ~prev_q &  sync_q[STAGES-1];
  assign fall  =  prev_q & ~sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/dac_serial_rx.sv
//==============================================================================
// dac_serial_rx: oversampling 3-wire DAC frame receiver; DAC_RX_ERRCNT_EN adds err_clr/err_count. Rev 1.0
//==============================================================================
`default_nettype none

module dac_serial_rx
  import dac_serial_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int DATA_W      = DATA_MSB + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sync,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        pd_mode,
  output logic              data_valid,
  output logic              frame_err,
`ifdef DAC_RX_ERRCNT_EN
  input  logic              err_clr,
  output logic [7:0]        err_count,
`endif
  output logic              busy
);

  // Only the low 14 frame bits are ever presented, so the top two bits fall off the end.
  localparam int              KEEP_W   = PD_MSB + 1;
  localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sync_lvl, sync_rise, sync_fall;
  logic din_s, din_rise, din_fall;

  dac_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .async_in(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  dac_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sync (
    .clk(clk), .rst_n(rst_n), .async_in(sync),
    .level(sync_lvl), .rise(sync_rise), .fall(sync_fall)
  );

  dac_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
    .clk(clk), .rst_n(rst_n), .async_in(din),
    .level(din_s), .rise(din_rise), .fall(din_fall)
  );

  logic unused_sync_taps;
  assign unused_sync_taps = ^{sclk_lvl, sclk_rise, sync_lvl, din_rise, din_fall};

  rx_state_t          state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [KEEP_W-1:0]  shift_q, shift_nxt;
  logic               load, abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      shift_q <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shift_nxt = shift_q;
    load      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_fall) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          shift_nxt = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == FULL_CNT) begin
          // A complete frame is published even if sync already rose; skip DONE then.
          load      = 1'b1;
          state_nxt = sync_rise ? IDLE : DONE;
        end else if (sync_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          shift_nxt = {shift_q[KEEP_W-2:0], din_s};
          cnt_nxt   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (sync_rise) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      pd_mode    <= PD_NORMAL;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load;
      frame_err  <= abort;
      if (load) begin
        data_out <= shift_q[DATA_W-1:0];
        pd_mode  <= shift_q[PD_MSB:PD_LSB];
      end
    end
  end

  assign busy = (state_q != IDLE);

`ifdef DAC_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (err_clr) begin
      err_count <= 8'd0;
    end else if (abort && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dac_serial_rx.sv
//==============================================================================
// tb_dac_serial_rx: directed self-checking bench for dac_serial_rx. Rev 1.0
//==============================================================================
`default_nettype none

module tb_dac_serial_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  logic        clk = 1'b0;
  logic        rst_n, sclk, sync, din;
  logic [11:0] data_out;
  logic [1:0]  pd_mode;
  logic        data_valid, frame_err, busy;
`ifdef DAC_RX_ERRCNT_EN
  logic        err_clr;
  logic [7:0]  err_count;
`endif

  int checks = 0, failures = 0;
  int v_pulses = 0, e_pulses = 0, both_seen = 0;
  int lat;

  dac_serial_rx #(.FRAME_BITS(16), .DATA_W(12), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sync(sync), .din(din),
    .data_out(data_out), .pd_mode(pd_mode),
    .data_valid(data_valid), .frame_err(frame_err),
`ifdef DAC_RX_ERRCNT_EN
    .err_clr(err_clr), .err_count(err_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (data_valid) v_pulses++;
    if (frame_err) e_pulses++;
    if (data_valid && frame_err) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    sync = 1'b0;
    wait_cyc(4);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din  = w[i];
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
      wait_cyc(HALF);
    end
  endtask

  task automatic end_frame(input int gap);
    sclk = 1'b1;
    wait_cyc(HALF);
    sync = 1'b1;
    wait_cyc(gap);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b1; sync = 1'b1; din = 1'b0;
`ifdef DAC_RX_ERRCNT_EN
    err_clr = 1'b0;
`endif
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(1);
    check("reset_data_out", data_out, 12'h000);
    check("reset_pd_mode", pd_mode, 2'b00);
    check("reset_valid", data_valid, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
`ifdef DAC_RX_ERRCNT_EN
    check("reset_err_count", err_count, 8'd0);
`endif
    wait_cyc(200);
    check("idle_no_valid", v_pulses, 0);
    check("idle_no_err", e_pulses, 0);
    check("idle_busy", busy, 1'b0);

    // Frame 0x0ABC with latency measured on the 16th sclk fall.
    start_frame();
    check("busy_in_frame", busy, 1'b1);
    shift_bits(32'h0ABC >> 1, 15);
    din  = 1'b0;
    sclk = 1'b1;
    wait_cyc(HALF);
    sclk = 1'b0;
    lat  = -1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (data_valid && lat < 0) lat = k;
    end
    check("latency_0ABC", lat, SYNC_STAGES + 1);
    end_frame(10);
    check("data_0ABC", data_out, 12'hABC);
    check("pd_0ABC", pd_mode, 2'b00);
    check("valid_cnt_0ABC", v_pulses, 1);
    check("err_cnt_0ABC", e_pulses, 0);
    check("busy_after_0ABC", busy, 1'b0);

    // Back-to-back frames with a 3-cycle sync-high gap.
    start_frame();
    shift_bits(32'h3FFF, 16);
    end_frame(3);
    check("data_3FFF", data_out, 12'hFFF);
    check("pd_3FFF", pd_mode, 2'b11);
    start_frame();
    shift_bits(32'h1555, 16);
    end_frame(10);
    check("data_1555", data_out, 12'h555);
    check("pd_1555", pd_mode, 2'b01);
    check("valid_cnt_b2b", v_pulses, 3);

    // Aborted frame after 10 bits.
    start_frame();
    shift_bits(32'h2AA, 10);
    end_frame(10);
    check("abort_err_cnt", e_pulses, 1);
    check("abort_valid_cnt", v_pulses, 3);
    check("abort_data_kept", data_out, 12'h555);
    check("abort_pd_kept", pd_mode, 2'b01);
    check("abort_busy", busy, 1'b0);
`ifdef DAC_RX_ERRCNT_EN
    check("abort_err_count", err_count, 8'd1);
`endif

    // 20 falls in one sync window: frame 0x0123 then 4 extra bits.
    start_frame();
    shift_bits(32'h0123A, 20);
    end_frame(10);
    check("extra_valid_cnt", v_pulses, 4);
    check("extra_data", data_out, 12'h123);
    check("extra_pd", pd_mode, 2'b00);
    check("extra_err_cnt", e_pulses, 1);

    // Reset in the middle of a frame, then a full frame.
    start_frame();
    shift_bits(32'h28, 8);
    sclk  = 1'b1;
    rst_n = 1'b0;
    sync  = 1'b1;
    wait_cyc(2);
    check("midrst_data", data_out, 12'h000);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(10);
    check("midrst_no_valid", v_pulses, 4);
    check("midrst_no_err", e_pulses, 1);
    start_frame();
    shift_bits(32'h2800, 16);
    end_frame(10);
    check("data_2800", data_out, 12'h800);
    check("pd_2800", pd_mode, 2'b10);
    check("valid_cnt_2800", v_pulses, 5);
    check("never_both", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dac_serial_rx.md
Name: dac_serial_rx

Overview:
- Receiving end of the three-wire DAC serial link (sclk, sync, din) driven by DAC_Top.
- Oversamples the link with the local clock and deserialises 16-bit frames: MSB first, din captured on sclk falling edge while sync is low.
- Presents the decoded 12-bit code and 2-bit power-down mode with a one-cycle valid strobe.
- Used as a loopback checker and DAC-side model in the DAC_NEW design.

Parameters:
- FRAME_BITS, 16, serial bits per frame.
- DATA_W, 12, width of the DAC code field (frame bits [11:0]).
- SYNC_STAGES, 2, synchroniser depth for sclk/sync/din; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  serial clock from transmitter, asynchronous to clk.
- sync  input  1  frame enable, active low.
- din  input  1  serial data.
- data_out  output  DATA_W  last good frame code, frame bits [11:0].
- pd_mode  output  2  last good frame power-down field, frame bits [13:12].
- data_valid  output  1  one-cycle pulse when data_out/pd_mode update.
- frame_err  output  1  one-cycle pulse on aborted frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Synchroniser stages reset to sclk=1, sync=1, din=0. Shift register and bit counter reset to 0. FSM enters IDLE.
- Input conditioning: each input passes SYNC_STAGES flops, then one edge-detect flop.
- Edge events:
  - fall_sclk = prev 1 & cur 0 on synchronised sclk.
  - fall_sync and rise_sync are detected the same way on synchronised sync.
- Timing constraint on the link: sclk high and low phases each ≥3 clk periods. sync setup to the first sclk fall ≥3 clk periods.
- FSM IDLE: busy=0. On fall_sync → SHIFT; clear counter and shift register.
- FSM SHIFT: busy=1.
  - On each fall_sclk, shift in synchronised din at the LSB and increment the counter.
  - When the counter reaches FRAME_BITS → DONE.
  - On rise_sync with counter < FRAME_BITS → pulse frame_err, → IDLE; outputs keep their old values.
- FSM DONE: busy=1.
  - Extra fall_sclk edges are ignored.
  - On rise_sync → IDLE.
- Output update:
  - On entry to DONE: data_out ← shift[11:0] and pd_mode ← shift[13:12] in the same clk cycle; data_valid=1 for exactly that cycle. Bits [15:14] are discarded.
  - Latency: data_valid is high in the cycle SYNC_STAGES+1 clk edges after the first clk edge that samples the 16th raw sclk low.
- Simultaneous events in SHIFT:
  - fall_sclk and rise_sync in the same cycle: sync takes priority and the edge is not counted. If the frame was at 15 bits, it aborts with frame_err.
- fall_sync while in DONE or SHIFT cannot occur without an intervening rise and needs no handling.
- Back-to-back frames: sync high for ≥3 clk periods between frames. A new frame starting the cycle after IDLE entry is accepted.
- Reset mid-frame: partial frame discarded; no data_valid or frame_err pulse.
- data_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro DAC_RX_ERRCNT_EN.
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments on every frame_err pulse and saturates at 255.
  - Adds input err_clr (1 bit, synchronous); err_clr zeroes the counter and wins over a simultaneous increment.
- Not defined: neither port exists; no counter logic.

Decomposition:
- Package dac_serial_pkg holds:
  - FRAME_BITS default, field positions PD_MSB=13, PD_LSB=12, DATA_MSB=11;
  - FSM state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - PD mode constants PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11.
- One sub-module, dac_rx_sync_edge: per-bit synchroniser plus rise/fall detector, instantiated for sclk and sync; din uses its synchronised output only.
- FSM and shift logic stay in the top.

Test Plan:
- Reset release, link idle (sync=1, sclk=1) → all outputs 0, busy=0, no pulses for 200 cycles.
- Frame 16'h0ABC, sclk half-period 5 clk → one data_valid pulse; data_out=12'hABC, pd_mode=2'b00, frame_err=0; latency checked against the SYNC_STAGES+1 rule.
- Frame 16'h3FFF then frame 16'h1555 back-to-back with 3-cycle sync gap → two valid pulses; (12'hFFF, 2'b11) then (12'h555, 2'b01).
- sync raised after 10 sclk falls → frame_err one pulse, data_out stays at previous value 12'h555, FSM returns IDLE. With DAC_RX_ERRCNT_EN, err_count=1.
- 20 sclk falls within one sync-low window, frame 16'h0123 followed by 4 extra bits → exactly one data_valid, data_out=12'h123.
- rst_n pulsed low after 8 bits of a frame, then full frame 16'h2800 → no pulse from the partial frame; then data_out=12'h800, pd_mode=2'b10.
